md_sched: RTL and testbench

Multiply/divide sequencer for the 5-stage MIPS pipeline. It sits beside the E-stage ALU and owns the HI/LO register pair. It accepts mult/multu/div/divu/mthi/mtlo from E and runs them with fixed multi-cycle latency. It also drives the stall request the D-stage hazard logic needs when a HI/LO-using instruction collides with a busy unit.

---
 rtl/md_if.sv | 24 ++
 rtl/md_sched.sv | 131 +++++++++++++
 tb/tb_md_sched.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/md_if.sv
// Handshake bundle between the E stage, D-stage hazard logic and the
// multiply/divide sequencer.
interface md_if;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        d_is_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        start;
  logic        stall_md;

  modport master (
    output md_op, rs_val, rt_val, cancel, d_is_md,
    input  hi, lo, busy, start, stall_md
  );

  modport slave (
    input  md_op, rs_val, rt_val, cancel, d_is_md,
    output hi, lo, busy, start, stall_md
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer owning HI/LO with fixed-latency mult/div.
// Optional macro MD_CANCEL_EN lets the E-stage flush suppress or abort operations.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic [31:0] r_sh_hi, w_sh_hi_nxt;
  logic [31:0] r_sh_lo, w_sh_lo_nxt;
  logic        r_sh_wr, w_sh_wr_nxt;

  logic        w_cancel;
`ifdef MD_CANCEL_EN
  assign w_cancel = bus.cancel;
`else
  logic w_unused_cancel;
  assign w_unused_cancel = bus.cancel;
  assign w_cancel        = 1'b0;
`endif

  logic w_is_mul, w_is_div, w_is_signed, w_is_mthi, w_is_mtlo, w_accept;
  assign w_is_mul    = (bus.md_op == 3'd1) || (bus.md_op == 3'd2);
  assign w_is_div    = (bus.md_op == 3'd3) || (bus.md_op == 3'd4);
  assign w_is_signed = (bus.md_op == 3'd1) || (bus.md_op == 3'd3);
  assign w_is_mthi   = (bus.md_op == 3'd5);
  assign w_is_mtlo   = (bus.md_op == 3'd6);
  assign w_accept    = (r_state == StIdle) && (w_is_mul || w_is_div) && !w_cancel;

  // Multiplier: operands extended to 64 bits so one unsigned multiply covers both signs.
  logic [63:0] w_mul_a, w_mul_b, w_prod;
  assign w_mul_a = {(w_is_signed ? {32{bus.rs_val[31]}} : 32'h0), bus.rs_val};
  assign w_mul_b = {(w_is_signed ? {32{bus.rt_val[31]}} : 32'h0), bus.rt_val};
  assign w_prod  = w_mul_a * w_mul_b;

  // Divider works on magnitudes; signs are restored afterwards (truncating division).
  logic        w_sa, w_sb, w_div_zero;
  logic [31:0] w_abs_a, w_abs_b, w_dvsr, w_uq, w_ur, w_quot, w_rem;
  assign w_sa       = w_is_signed && bus.rs_val[31];
  assign w_sb       = w_is_signed && bus.rt_val[31];
  assign w_abs_a    = w_sa ? (32'h0 - bus.rs_val) : bus.rs_val;
  assign w_abs_b    = w_sb ? (32'h0 - bus.rt_val) : bus.rt_val;
  assign w_div_zero = (bus.rt_val == 32'h0);
  assign w_dvsr     = w_div_zero ? 32'h1 : w_abs_b;
  assign w_uq       = w_abs_a / w_dvsr;
  assign w_ur       = w_abs_a % w_dvsr;
  assign w_quot     = (w_sa ^ w_sb) ? (32'h0 - w_uq) : w_uq;
  assign w_rem      = w_sa ? (32'h0 - w_ur) : w_ur;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_sh_hi_nxt = r_sh_hi;
    w_sh_lo_nxt = r_sh_lo;
    w_sh_wr_nxt = r_sh_wr;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = StRun;
          if (w_is_mul) begin
            w_sh_hi_nxt = w_prod[63:32];
            w_sh_lo_nxt = w_prod[31:0];
            w_sh_wr_nxt = 1'b1;
            w_cnt_nxt   = 4'(MULT_CYCLES);
          end else begin
            w_sh_hi_nxt = w_rem;
            w_sh_lo_nxt = w_quot;
            w_sh_wr_nxt = !w_div_zero;
            w_cnt_nxt   = 4'(DIV_CYCLES);
          end
        end else if (!w_cancel && w_is_mthi) begin
          w_hi_nxt = bus.rs_val;
        end else if (!w_cancel && w_is_mtlo) begin
          w_lo_nxt = bus.rs_val;
        end
      end
      StRun: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (w_cancel) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = StIdle;
          if (r_sh_wr) begin
            w_hi_nxt = r_sh_hi;
            w_lo_nxt = r_sh_lo;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_hi    <= 32'h0;
      r_lo    <= 32'h0;
      r_sh_hi <= 32'h0;
      r_sh_lo <= 32'h0;
      r_sh_wr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_sh_hi <= w_sh_hi_nxt;
      r_sh_lo <= w_sh_lo_nxt;
      r_sh_wr <= w_sh_wr_nxt;
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = (r_state == StRun);
  assign bus.start    = w_accept;
  assign bus.stall_md = bus.d_is_md && (bus.busy || w_accept);

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched: vector table plus stall, cancel
// and reset-in-flight sequences.
module tb_md_sched;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  md_if u_if ();

  md_sched u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_start;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present an op for one E cycle starting at a negedge; checks start combinationally.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic exp_start);
    @(negedge clk);
    u_if.md_op  = op;
    u_if.rs_val = rs;
    u_if.rt_val = rt;
    #1;
    chk("start", 32'(u_if.start), 32'(exp_start));
    @(posedge clk);
    #1;
    u_if.md_op = 3'd0;
  endtask

  task automatic expect_busy(input int cycles, input string name);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk(name, 32'(u_if.busy), 32'd1);
    end
    @(negedge clk);
    chk({name, "_fall"}, 32'(u_if.busy), 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{3'd4, 32'd100,      32'd7,        1'b1, 10, 32'd2,        32'd14};
    vecs[3] = '{3'd3, 32'hFFFFFFF9, 32'd2,        1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 32'h00000000, 32'h80000000};
    vecs[5] = '{3'd5, 32'h12345678, 32'd0,        1'b0, 0,  32'h12345678, 32'h80000000};
    vecs[6] = '{3'd6, 32'hCAFEBABE, 32'd0,        1'b0, 0,  32'h12345678, 32'hCAFEBABE};
    vecs[7] = '{3'd4, 32'd55,       32'd0,        1'b1, 10, 32'h12345678, 32'hCAFEBABE};
    vecs[8] = '{3'd1, 32'd7,        32'hFFFFFFFF, 1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[9] = '{3'd7, 32'h55555555, 32'd1,        1'b0, 0,  32'hFFFFFFFF, 32'hFFFFFFF9};

    u_if.md_op   = 3'd0;
    u_if.rs_val  = 32'h0;
    u_if.rt_val  = 32'h0;
    u_if.cancel  = 1'b0;
    u_if.d_is_md = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", u_if.hi, 32'h0);
    chk("rst_lo", u_if.lo, 32'h0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_start);
      expect_busy(vecs[i].cycles, $sformatf("v%0d_busy", i));
      chk($sformatf("v%0d_hi", i), u_if.hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), u_if.lo, vecs[i].exp_lo);
    end

    // Back-to-back mthi/mtlo, each visible one cycle later.
    @(negedge clk);
    u_if.md_op  = 3'd5;
    u_if.rs_val = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    u_if.md_op  = 3'd6;
    u_if.rs_val = 32'h5A5A5A5A;
    chk("b2b_hi", u_if.hi, 32'hA5A5A5A5);
    chk("b2b_busy", 32'(u_if.busy), 32'd0);
    @(posedge clk);
    #1;
    u_if.md_op = 3'd0;
    chk("b2b_lo", u_if.lo, 32'h5A5A5A5A);
    chk("b2b_start", 32'(u_if.start), 32'd0);

    // Hazard stall: D-stage md instruction behind a divu.
    @(negedge clk);
    u_if.md_op  = 3'd4;
    u_if.rs_val = 32'd100;
    u_if.rt_val = 32'd7;
    #1;
    chk("stall_e0", 32'(u_if.stall_md), 32'd0);
    @(posedge clk);
    #1;
    u_if.md_op   = 3'd0;
    u_if.d_is_md = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_run", 32'(u_if.stall_md), 32'd1);
    end
    @(negedge clk);
    chk("stall_drop", 32'(u_if.stall_md), 32'd0);
    chk("stall_lo", u_if.lo, 32'd14);
    chk("stall_hi", u_if.hi, 32'd2);
    u_if.d_is_md = 1'b0;

    // Mult with cancel in its E cycle.
    @(negedge clk);
    u_if.md_op  = 3'd1;
    u_if.rs_val = 32'd3;
    u_if.rt_val = 32'd5;
    u_if.cancel = 1'b1;
    #1;
`ifdef MD_CANCEL_EN
    chk("cmul_start", 32'(u_if.start), 32'd0);
`else
    chk("cmul_start", 32'(u_if.start), 32'd1);
`endif
    @(posedge clk);
    #1;
    u_if.md_op  = 3'd0;
    u_if.cancel = 1'b0;
`ifdef MD_CANCEL_EN
    expect_busy(0, "cmul_busy");
    chk("cmul_hi", u_if.hi, 32'd2);
    chk("cmul_lo", u_if.lo, 32'd14);
`else
    expect_busy(5, "cmul_busy");
    chk("cmul_hi", u_if.hi, 32'd0);
    chk("cmul_lo", u_if.lo, 32'd15);
`endif

    // Div with cancel pulsed in its 3rd busy cycle.
    issue(3'd3, 32'd40, 32'd6, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("cdiv_busy", 32'(u_if.busy), 32'd1);
    end
    u_if.cancel = 1'b1;
    @(posedge clk);
    #1;
    u_if.cancel = 1'b0;
`ifdef MD_CANCEL_EN
    chk("cdiv_abort", 32'(u_if.busy), 32'd0);
    @(negedge clk);
    chk("cdiv_hi", u_if.hi, 32'd2);
    chk("cdiv_lo", u_if.lo, 32'd14);
`else
    expect_busy(7, "cdiv_busy");
    chk("cdiv_hi", u_if.hi, 32'd4);
    chk("cdiv_lo", u_if.lo, 32'd6);
`endif

    // Reset in the 3rd busy cycle of a mult, then a fresh mult.
    issue(3'd1, 32'd9, 32'd9, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rmul_busy", 32'(u_if.busy), 32'd1);
    end
    reset = 1'b1;
    #1;
    chk("rmul_busy0", 32'(u_if.busy), 32'd0);
    chk("rmul_hi0", u_if.hi, 32'd0);
    chk("rmul_lo0", u_if.lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(3'd1, 32'd6, 32'd7, 1'b1);
    expect_busy(5, "rmul2_busy");
    chk("rmul2_hi", u_if.hi, 32'd0);
    chk("rmul2_lo", u_if.lo, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
